// File: rtl/vproc_mul_iter.sv
// vproc_mul_iter: iterative 32x32 integer multiplier (MUL/MULH/MULHSU/MULHU).
// Retires RADIX_BITS multiplier bits per cycle on unsigned magnitudes, then
// applies the product sign when the result is presented.
//
// Ports:
//   clk_i, sync_rst_i        clock, synchronous active-high reset
//   flush_i                  abandon any in-flight operation
//   req_valid_i/req_ready_o  request handshake
//   req_op_i                 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_op1_i, req_op2_i     multiplicand, multiplier
//   req_tag_i                opaque tag returned with the result
//   res_valid_o/res_ready_i  result handshake
//   res_o, res_tag_o         result word and its tag
module vproc_mul_iter #(
  parameter int unsigned RADIX_BITS = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk_i,
  input  logic             sync_rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_op1_i,
  input  logic [31:0]      req_op2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_o,
  output logic [TAG_W-1:0] res_tag_o
);

  localparam int unsigned N     = 32 / RADIX_BITS;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               neg_q, neg_d;
  logic [63:0]        mcand_q, mcand_d;
  logic [31:0]        mplier_q, mplier_d;
  logic [63:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               s1, s2;
  logic [63:0]        pp;
  logic [63:0]        prod;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    req_ready_o = (state_q == IDLE) || ((state_q == DONE) && res_ready_i);
    accept      = req_valid_i && req_ready_o && !flush_i;

    s1 = req_op1_i[31] && ((req_op_i == 2'b01) || (req_op_i == 2'b10));
    s2 = req_op2_i[31] && (req_op_i == 2'b01);

    // Partial product of the pre-shifted multiplicand and the low multiplier digit.
    pp = '0;
    for (int unsigned b = 0; b < RADIX_BITS; b++) begin
      if (mplier_q[b]) begin
        pp = pp + (mcand_q << b);
      end
    end

    unique case (state_q)
      IDLE: ;
      BUSY: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept only happens in IDLE/DONE, so it never collides with the BUSY step.
    if (accept) begin
      state_d  = BUSY;
      op_d     = req_op_i;
      tag_d    = req_tag_i;
      neg_d    = s1 ^ s2;
      mcand_d  = {32'b0, (s1 ? (-req_op1_i) : req_op1_i)};
      mplier_d = s2 ? (-req_op2_i) : req_op2_i;
      acc_d    = '0;
      cnt_d    = CNT_W'(N - 1);
    end

    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Magnitude product becomes signed here; 0x80000000 magnitudes stay correct
  // because the accumulator is 64 bits wide.
  assign prod        = neg_q ? (-acc_q) : acc_q;
  assign res_valid_o = (state_q == DONE);
  assign res_o       = res_valid_o ? ((op_q == 2'b00) ? prod[31:0] : prod[63:32]) : '0;
  assign res_tag_o   = res_valid_o ? tag_q : '0;

endmodule

// File: tb/tb_vproc_mul_iter.sv
// Bench for vproc_mul_iter: four instances (RADIX_BITS 1,2,4,8), a
// transaction-level model checked every cycle, plus directed literal vectors.
module tb_vproc_mul_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid [4];
  logic        req_ready [4];
  logic [1:0]  req_op    [4];
  logic [31:0] req_op1   [4];
  logic [31:0] req_op2   [4];
  logic [3:0]  req_tag   [4];
  logic        res_valid [4];
  logic        res_ready [4];
  logic [31:0] res       [4];
  logic [3:0]  res_tag   [4];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // model state: at most one outstanding op per instance
  bit          pend  [4];
  logic [31:0] m_res [4];
  logic [3:0]  m_tag [4];
  int          m_due [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    vproc_mul_iter #(.RADIX_BITS(1 << g), .TAG_W(4)) u_dut (
      .clk_i      (clk),
      .sync_rst_i (rst),
      .flush_i    (flush),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_op_i   (req_op[g]),
      .req_op1_i  (req_op1[g]),
      .req_op2_i  (req_op2[g]),
      .req_tag_i  (req_tag[g]),
      .res_valid_o(res_valid[g]),
      .res_ready_i(res_ready[g]),
      .res_o      (res[g]),
      .res_tag_o  (res_tag[g])
    );
  end

  function automatic int nof(input int i);
    return 32 >> i;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = ((op == 2'b01) || (op == 2'b10)) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d @cyc %0d: got %h expected %h", name, i, cyc, got, exp);
    end
  endtask

  // Compare process: outputs vs. model every cycle, then advance the model.
  initial begin : compare
    bit ev, er;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        for (int i = 0; i < 4; i++) begin
          ev = pend[i] && (cyc >= m_due[i]);
          er = !pend[i] || (ev && res_ready[i]);
          chk("res_valid", i, 32'(res_valid[i]), 32'(ev));
          chk("req_ready", i, 32'(req_ready[i]), 32'(er));
          if (ev) begin
            chk("res", i, res[i], m_res[i]);
            chk("res_tag", i, 32'(res_tag[i]), 32'(m_tag[i]));
          end
          if (rst || flush) begin
            pend[i] = 1'b0;
          end else begin
            if (ev && res_ready[i]) pend[i] = 1'b0;
            if (req_valid[i] && er) begin
              pend[i]  = 1'b1;
              m_res[i] = ref_mul(req_op[i], req_op1[i], req_op2[i]);
              m_tag[i] = req_tag[i];
              m_due[i] = cyc + nof(i) + 1;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, output int waits);
    bit ok = 1'b0;
    waits = 0;
    req_op[i] = op; req_op1[i] = a; req_op2[i] = b; req_tag[i] = t; req_valid[i] = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i] && !flush && !rst) ok = 1'b1;
      else waits++;
      step();
    end
    req_valid[i] = 1'b0;
    // scramble inputs after accept; they must not affect the result
    req_op[i] = 2'($urandom_range(3)); req_op1[i] = $urandom; req_op2[i] = $urandom; req_tag[i] = 4'($urandom);
    if (!ok) chk("issue_timeout", i, 32'd0, 32'd1);
  endtask

  // Ends at the negedge where res_valid is seen (not consumed yet).
  task automatic get_result(input int i, output logic [31:0] r, output logic [3:0] t, output int lat);
    bit got = 1'b0;
    lat = 0; r = '0; t = '0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (res_valid[i]) begin
        got = 1'b1; r = res[i]; t = res_tag[i];
      end else begin
        step();
        lat++;
      end
    end
    if (!got) chk("result_timeout", i, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_req(input int i);
    req_op[i] = 2'($urandom_range(3)); req_op1[i] = pick(); req_op2[i] = pick(); req_tag[i] = 4'($urandom);
  endtask

  task automatic run_stream(input int i, input int n);
    int sent = 0;
    int guard = 0;
    bit acc;
    rand_req(i);
    req_valid[i] = 1'b1;
    while (sent < n && guard < 100000) begin
      @(negedge clk);
      acc = req_ready[i];
      step();
      guard++;
      res_ready[i] = ($urandom_range(3) != 0);
      if (acc) begin
        sent++;
        rand_req(i);
      end
    end
    req_valid[i] = 1'b0;
    res_ready[i] = 1'b1;
    if (sent < n) chk("stream_timeout", i, 32'(sent), 32'(n));
    repeat (40) step();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  t;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9] = '{
    '{2'b00, 32'h1234_5678, 32'h0000_0010, 4'd3,  32'h2345_6780},
    '{2'b01, 32'h8000_0000, 32'h8000_0000, 4'd4,  32'h4000_0000},
    '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5,  32'h0000_0000},
    '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 4'd6,  32'hFFFF_FFFF},
    '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7,  32'hFFFF_FFFF},
    '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8,  32'hFFFF_FFFE},
    '{2'b00, 32'h0000_0000, 32'h0000_0000, 4'd9,  32'h0000_0000},
    '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'h0000_0001},
    '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 4'd11, 32'hC000_0000}
  };

  task automatic abort_test(input bit use_rst);
    int w, lat;
    logic [31:0] r;
    logic [3:0] t;
    issue(1, 2'b00, 32'd3, 32'd5, 4'd1, w);
    repeat (6) step();
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk(use_rst ? "abort_rst_valid" : "abort_flush_valid", 1, 32'(res_valid[1]), 32'd0);
    chk(use_rst ? "abort_rst_ready" : "abort_flush_ready", 1, 32'(req_ready[1]), 32'd1);
    repeat (20) step();
    issue(1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 4'd12, w);
    get_result(1, r, t, lat);
    chk("after_abort_res", 1, r, 32'hFFFF_FFFF);
    chk("after_abort_tag", 1, 32'(t), 32'd12);
    step();
  endtask

  initial begin : driver
    int w, lat;
    logic [31:0] r, r0;
    logic [3:0] t;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0; req_op[i] = '0; req_op1[i] = '0; req_op2[i] = '0;
      req_tag[i] = '0; res_ready[i] = 1'b1; pend[i] = 1'b0; m_due[i] = 0;
      m_res[i] = '0; m_tag[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", i, 32'(res_valid[i]), 32'd0);
      chk("rst_ready", i, 32'(req_ready[i]), 32'd1);
      chk("rst_res", i, res[i], 32'd0);
      chk("rst_tag", i, 32'(res_tag[i]), 32'd0);
    end
    chk_en = 1'b1;
    step();

    // directed literal vectors on the RADIX_BITS=2 instance
    foreach (vecs[v]) begin
      issue(1, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].t, w);
      get_result(1, r, t, lat);
      chk("vec_res", v, r, vecs[v].exp);
      chk("vec_tag", v, 32'(t), 32'(vecs[v].t));
      chk("vec_latency", v, 32'(lat), 32'd16);
      step();
    end

    // backpressure, then back-to-back accept while consuming the result
    res_ready[1] = 1'b0;
    issue(1, 2'b11, 32'hDEAD_BEEF, 32'h0000_0010, 4'd5, w);
    get_result(1, r0, t, lat);
    chk("bp_res", 1, r0, 32'h0000_000D);
    chk("bp_latency", 1, 32'(lat), 32'd16);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("bp_hold_res", 1, res[1], r0);
      chk("bp_hold_tag", 1, 32'(res_tag[1]), 32'd5);
      chk("bp_hold_ready", 1, 32'(req_ready[1]), 32'd0);
    end
    step();
    res_ready[1] = 1'b1;
    issue(1, 2'b00, 32'd7, 32'd6, 4'd9, w);
    chk("b2b_waits", 1, 32'(w), 32'd0);
    get_result(1, r, t, lat);
    chk("b2b_res", 1, r, 32'd42);
    chk("b2b_tag", 1, 32'(t), 32'd9);
    chk("b2b_latency", 1, 32'(lat), 32'd16);
    step();

    // flush while idle with a request pending: must not be accepted
    req_valid[1] = 1'b1; req_op[1] = 2'b00; req_op1[1] = 32'd2; req_op2[1] = 32'd2;
    flush = 1'b1;
    step();
    flush = 1'b0; req_valid[1] = 1'b0;
    repeat (20) step();

    abort_test(1'b0);
    abort_test(1'b1);

    for (int i = 0; i < 4; i++) run_stream(i, 250);
    for (int i = 0; i < 4; i++) chk("drained", i, 32'(pend[i]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vproc_mul_iter.md
Name: vproc_mul_iter

Overview:
- Iterative multi-cycle 32x32 integer multiplier.
- It is the inverse-operation companion to the vector unit's division block. Multiplication pairs with division, and it gives the element pipeline a low-area multiply path for configurations without DSP multipliers.
- It accepts one operand pair per request over a valid/ready handshake and computes RADIX_BITS partial-product bits per cycle.
- It returns the low or high 32-bit word of the 64-bit product for MUL/MULH/MULHSU/MULHU semantics, with a pass-through tag.

Parameters:
- RADIX_BITS, 2, multiplier bits retired per cycle. Legal values are 1, 2, 4, 8. N = 32/RADIX_BITS iteration cycles.
- TAG_W, 4, width of the opaque request tag returned with the result.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- sync_rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  abandon any in-flight operation; synchronous
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when both valid and ready are high at a rising edge
- req_op_i  in  2  00=MUL (low word, signedness irrelevant), 01=MULH (s x s), 10=MULHSU (op1 signed, op2 unsigned), 11=MULHU (u x u)
- req_op1_i  in  32  multiplicand
- req_op2_i  in  32  multiplier
- req_tag_i  in  TAG_W  request tag
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed when both valid and ready are high at a rising edge
- res_o  out  32  result word
- res_tag_o  out  TAG_W  tag of the result

Behaviour:
- FSM states are IDLE, BUSY, DONE.
- Reset (sync_rst_i=1 at an edge) sets state=IDLE and clears all internal registers. After reset: res_valid_o=0, req_ready_o=1, res_o=0, res_tag_o=0. Reset mid-operation discards the operation with no result.
- req_ready_o = (state==IDLE) | (state==DONE & res_ready_i). It is combinational from res_ready_i and never depends on req_valid_i.
- Accept edge:
  - Latch op, tag, and sign flags:
    - s1 = op1[31] & (op 01 or 10)
    - s2 = op2[31] & (op 01)
  - Latch magnitudes |op1| and |op2| as 32-bit unsigned. The magnitude of 0x80000000 is 0x80000000.
  - Clear the 64-bit accumulator, load counter = N-1, go to BUSY.
- BUSY, each edge:
  - Add (multiplicand x low RADIX_BITS of the multiplier) << (position), or the equivalent shift-add.
  - Shift the multiplier right by RADIX_BITS and decrement the counter.
  - At the edge where counter==0, go to DONE.
- Latency: res_valid_o is high exactly N cycles after the accept edge. Default N=16.
- DONE:
  - res_valid_o=1.
  - Product P = acc, negated (64-bit two's complement) when s1^s2.
  - res_o = P[31:0] for MUL, otherwise P[63:32]. The output is stable while res_valid_o=1 & res_ready_i=0.
- DONE with res_ready_i=1 at an edge:
  - If req_valid_i=1, accept the new request directly into BUSY (back-to-back throughput of one result per N+1 cycles).
  - Otherwise go to IDLE.
- flush_i=1 at an edge: state=IDLE and res_valid_o=0 next cycle. Any concurrent request is not accepted, even though ready is high that cycle. flush has priority over the handshake; reset has priority over flush.
- Width and arithmetic rules: there is no overflow exception; results wrap modulo 2^64. Operands equal to zero still take the full N cycles (fixed latency, no early termination).
- Inputs are sampled only on the accept edge; changes to req_* afterwards have no effect.

Test Plan:
- MUL 0x12345678 x 0x00000010, tag 3 -> res_o=0x23456780, res_tag_o=3. res_valid_o rises exactly 16 cycles after accept (RADIX_BITS=2).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- Backpressure then back-to-back:
  - Hold res_ready_i=0 for 5 cycles in DONE; res_o and res_tag_o stay stable and req_ready_o=0.
  - Raise res_ready_i with req_valid_i=1; the next request is accepted in the same cycle and its result appears N cycles later.
- sync_rst_i pulsed, and separately flush_i pulsed, in the 7th BUSY cycle -> IDLE next cycle, res_valid_o never rises for that op. A new request then returns the correct result.
- Randomized stream of 1000 ops across all req_op_i and RADIX_BITS in {1,2,4,8} -> every result matches a 64-bit reference product; latency always equals 32/RADIX_BITS.
